// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache: 8 lines of 4 bytes.
// The CPU side answers hits combinationally; misses run WRITEBACK/FETCH/UPDATE.
module dcache (
    input  logic        clk,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [7:0]  address,
    input  logic [7:0]  writedata,
    output logic [7:0]  readdata,
    output logic        busywait,
    output logic        mem_read,
    output logic        mem_write,
    output logic [5:0]  mem_address,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_busywait
);

    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

    state_t      state, next_state;
    logic [7:0]  valid, dirty;
    logic [2:0]  tags [8];
    logic [31:0] data [8];
    logic [2:0]  miss_tag, miss_index;
    logic [31:0] fill_block;

    logic [2:0] tag, index;
    logic [1:0] offset;
    logic       request, hit, write_hit;

    assign tag       = address[7:5];
    assign index     = address[4:2];
    assign offset    = address[1:0];
    assign request   = read | write;
    assign hit       = valid[index] && (tags[index] == tag);
    assign write_hit = (state == IDLE) && write && hit;

    // Control state: everything here must be cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            valid      <= '0;
            dirty      <= '0;
            miss_tag   <= '0;
            miss_index <= '0;
            fill_block <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (write_hit) begin
                        dirty[index] <= 1'b1;
                    end else if (request && !hit) begin
                        miss_tag   <= tag;
                        miss_index <= index;
                    end
                end
                FETCH: begin
                    if (!mem_busywait) fill_block <= mem_readdata;
                end
                UPDATE: begin
                    valid[miss_index] <= 1'b1;
                    dirty[miss_index] <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays keep their contents across reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (write_hit) begin
            data[index][{offset, 3'b000} +: 8] <= writedata;
        end else if (state == UPDATE) begin
            data[miss_index] <= fill_block;
            tags[miss_index] <= miss_tag;
        end
    end

    always_comb begin
        next_state    = state;
        busywait      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        readdata      = '0;
        case (state)
            IDLE: begin
                if (request && !hit) begin
                    busywait   = 1'b1;
                    next_state = (valid[index] && dirty[index]) ? WRITEBACK : FETCH;
                end else if (read && !write && hit) begin
                    readdata = data[index][{offset, 3'b000} +: 8];
                end
            end
            WRITEBACK: begin
                busywait      = 1'b1;
                mem_write     = 1'b1;
                mem_address   = {tags[miss_index], miss_index};
                mem_writedata = data[miss_index];
                if (!mem_busywait) next_state = FETCH;
            end
            FETCH: begin
                busywait    = 1'b1;
                mem_read    = 1'b1;
                mem_address = {miss_tag, miss_index};
                if (!mem_busywait) next_state = UPDATE;
            end
            UPDATE: begin
                busywait   = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        // A held request must not raise a stall while reset is asserted.
        if (reset) begin
            busywait  = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            readdata  = '0;
        end
    end

endmodule
